// File: rtl/amul_pkg.sv
// Shared widths for the approximate-multiplier scheduler and its core.
package amul_pkg;
   localparam int OP_W    = 8;
   localparam int PROD_W  = 16;
   localparam int TAG_W   = 3;
   localparam int MAX_REQ = 8;
   localparam int CNT_W   = 16;
endpackage

// File: rtl/amul_core.sv
// Combinational approximate 8x8 multiplier: drops x[1:0] partial rows and
// patches in the two most significant missing product bits.
module amul_core
   import amul_pkg::*;
(
   input  logic [OP_W-1:0]   x,
   input  logic [OP_W-1:0]   y,
   output logic [PROD_W-1:0] z
);
   localparam int PART_W = PROD_W - 2;

   logic [PART_W-1:0] partial;
   logic              bit7;
   logic              bit8;

   assign partial = PART_W'(y) * PART_W'(x[OP_W-1:2]);
   assign bit7    = (x[0] & y[6]) | (x[1] & y[5]);
   assign bit8    = x[1] & y[7];
   assign z       = {partial, 2'b00} + (PROD_W'({bit8, bit7}) << 7);
endmodule

// File: rtl/amul_sched.sv
// Round-robin scheduler sharing one two-stage multiplier among NUM_REQ requesters.
// Optional macro AMUL_SCHED_EXACT_EN adds a per-request exact-product select.
module amul_sched
   import amul_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*OP_W-1:0]   req_x,
   input  logic [NUM_REQ*OP_W-1:0]   req_y,
`ifdef AMUL_SCHED_EXACT_EN
   input  logic [NUM_REQ-1:0]        req_exact,
`endif
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [PROD_W-1:0]         res_z,
   output logic [TAG_W-1:0]          res_tag,
   output logic [CNT_W-1:0]          acc_cnt
);
   logic [TAG_W-1:0]  rr_ptr;
   logic [TAG_W-1:0]  grant_idx;
   logic              grant_found;
   logic [OP_W-1:0]   sel_x;
   logic [OP_W-1:0]   sel_y;
   logic              sel_exact;

   logic              s1_valid;
   logic [OP_W-1:0]   s1_x;
   logic [OP_W-1:0]   s1_y;
   logic [TAG_W-1:0]  s1_tag;
   logic              s1_exact;

   logic              s2_ready;
   logic              s1_adv;
   logic              s1_move;
   logic              accept;
   logic [PROD_W-1:0] core_z;
   logic [PROD_W-1:0] s2_z;

   assign s2_ready = !res_valid || res_ready;
   assign s1_adv   = !s1_valid || !res_valid || res_ready;
   assign s1_move  = s1_valid && s2_ready;
   assign accept   = grant_found && s1_adv && rst_n;

   // Search offsets from rr_ptr; rr_ptr+k may exceed NUM_REQ-1, hence the wrapped compare.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] &&
                ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NUM_REQ))) begin
               grant_found = 1'b1;
               grant_idx   = TAG_W'(i);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_x     = '0;
      sel_y     = '0;
      sel_exact = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == TAG_W'(i)) begin
            req_ready[i] = accept;
            sel_x        = req_x[i*OP_W +: OP_W];
            sel_y        = req_y[i*OP_W +: OP_W];
`ifdef AMUL_SCHED_EXACT_EN
            sel_exact    = req_exact[i];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         acc_cnt  <= '0;
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_tag   <= '0;
         s1_exact <= 1'b0;
      end else if (accept) begin
         rr_ptr   <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
         acc_cnt  <= acc_cnt + CNT_W'(1);
         s1_valid <= 1'b1;
         s1_x     <= sel_x;
         s1_y     <= sel_y;
         s1_tag   <= grant_idx;
         s1_exact <= sel_exact;
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   amul_core u_core (
      .x (s1_x),
      .y (s1_y),
      .z (core_z)
   );

`ifdef AMUL_SCHED_EXACT_EN
   assign s2_z = s1_exact ? (PROD_W'(s1_x) * PROD_W'(s1_y)) : core_z;
`else
   assign s2_z = core_z;
`endif

   // Output register only loads when empty or draining, so a stalled result holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_z     <= '0;
         res_tag   <= '0;
      end else if (s2_ready) begin
         res_valid <= s1_valid;
         if (s1_valid) begin
            res_z   <= s2_z;
            res_tag <= s1_tag;
         end
      end
   end
endmodule

// File: tb/tb_amul_sched.sv
// Randomized self-checking bench for amul_sched against a queue-based reference model.
module tb_amul_sched;
   localparam int N = 4;
`ifdef AMUL_SCHED_EXACT_EN
   localparam bit EXACT_ON = 1'b1;
`else
   localparam bit EXACT_ON = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*8-1:0] req_x;
   logic [N*8-1:0] req_y;
   logic [N-1:0]  req_exact;
   logic          res_valid;
   logic          res_ready;
   logic [15:0]   res_z;
   logic [2:0]    res_tag;
   logic [15:0]   acc_cnt;

   typedef struct {
      logic [15:0] z;
      logic [2:0]  tag;
      int          acc_edge;
   } item_t;

   item_t       q[$];
   int          edge_cnt;
   int          m_ptr;
   logic [15:0] m_cnt;
   int          checks;
   int          errors;

   amul_sched #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
`ifdef AMUL_SCHED_EXACT_EN
      .req_exact (req_exact),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_z     (res_z),
      .res_tag   (res_tag),
      .acc_cnt   (acc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Product straight from the arithmetic definition of the approximation.
   function automatic logic [15:0] refProduct(input int x, input int y, input bit e);
      int p;
      if (e && EXACT_ON) return 16'(x * y);
      p = y * (x / 4) * 4;
      if (((x % 2) == 1 && ((y / 64) % 2) == 1) || (((x / 2) % 2) == 1 && ((y / 32) % 2) == 1))
         p += 128;
      if (((x / 2) % 2) == 1 && ((y / 128) % 2) == 1)
         p += 256;
      return 16'(p % 65536);
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic stepCycle(input logic [N-1:0] v, input logic [N*8-1:0] xs, input logic [N*8-1:0] ys,
                            input logic [N-1:0] ex, input logic rr);
      int          g;
      int          j;
      logic [N-1:0] exp_ready;
      bit          pres;
      item_t       it;
      req_valid = v;
      req_x     = xs;
      req_y     = ys;
      req_exact = ex;
      res_ready = rr;
      #1;
      g         = -1;
      exp_ready = '0;
      if (q.size() < 2 || rr) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && v[j]) g = j;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      pres = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
      checkOutput("res_valid", 32'(res_valid), 32'(pres));
      if (pres) begin
         checkOutput("res_z", 32'(res_z), 32'(q[0].z));
         checkOutput("res_tag", 32'(res_tag), 32'(q[0].tag));
      end
      @(posedge clk);
      edge_cnt++;
      if (pres && rr) void'(q.pop_front());
      if (g >= 0) begin
         it.z        = refProduct(int'(xs[8*g +: 8]), int'(ys[8*g +: 8]), ex[g]);
         it.tag      = 3'(g);
         it.acc_edge = edge_cnt;
         q.push_back(it);
         m_ptr = (g + 1) % N;
         m_cnt = m_cnt + 16'd1;
      end
      #1;
      checkOutput("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
      @(negedge clk);
   endtask

   task automatic applyReset();
      req_valid = '1;
      rst_n     = 1'b0;
      #1;
      checkOutput("rst_res_valid", 32'(res_valid), 0);
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_acc_cnt", 32'(acc_cnt), 0);
      checkOutput("rst_res_z", 32'(res_z), 0);
      checkOutput("rst_res_tag", 32'(res_tag), 0);
      q.delete();
      m_ptr = 0;
      m_cnt = '0;
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   task automatic directedProduct(input int idx, input logic [7:0] x, input logic [7:0] y,
                                  input logic ex, input logic [15:0] expz, input string tag);
      stepCycle(N'(1 << idx), 32'(x) << (8 * idx), 32'(y) << (8 * idx), N'(ex) << idx, 1'b1);
      stepCycle('0, '0, '0, '0, 1'b1);
      #1;
      checkOutput({tag, "_valid"}, 32'(res_valid), 1);
      checkOutput({tag, "_z"}, 32'(res_z), 32'(expz));
      checkOutput({tag, "_tag"}, 32'(res_tag), 32'(idx));
      stepCycle('0, '0, '0, '0, 1'b1);
   endtask

   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++)
         stepCycle(N'($urandom_range(0, 15)), $urandom, $urandom, N'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      edge_cnt  = 0;
      req_x     = '0;
      req_y     = '0;
      req_exact = '0;
      res_ready = 1'b1;
      applyReset();

      directedProduct(0, 8'd255, 8'd255, 1'b0, 16'd64644, "p255");
      directedProduct(1, 8'd3, 8'd255, 1'b0, 16'd384, "p3x255");
      directedProduct(2, 8'd4, 8'd10, 1'b0, 16'd40, "p4x10");
`ifdef AMUL_SCHED_EXACT_EN
      directedProduct(3, 8'd255, 8'd255, 1'b1, 16'd65025, "exact");
`endif

      // All requesters busy with a free consumer: one grant per cycle in rotation.
      for (int c = 0; c < 10; c++) stepCycle('1, $urandom, $urandom, '0, 1'b1);
      repeat (3) stepCycle('0, '0, '0, '0, 1'b1);

      // Consumer stalls: pipeline fills, then holds until released.
      for (int c = 0; c < 5; c++) stepCycle('1, $urandom, $urandom, '0, 1'b0);
      repeat (4) stepCycle('0, '0, '0, '0, 1'b1);

      applyStimulus(1500);

      // Reset with both stages full must discard everything in flight.
      repeat (3) stepCycle('1, $urandom, $urandom, '0, 1'b0);
      checkOutput("full_res_valid", 32'(res_valid), 1);
      applyReset();
      repeat (4) stepCycle('0, '0, '0, '0, 1'b1);

      for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++)
         stepCycle(N'(1), $urandom, $urandom, '0, 1'b1);
      checkOutput("cnt_ffff", 32'(acc_cnt), 32'h0000FFFF);
      stepCycle(N'(1), $urandom, $urandom, '0, 1'b1);
      checkOutput("cnt_wrap", 32'(acc_cnt), 0);
      repeat (3) stepCycle('0, '0, '0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/amul_sched.md
AMUL_SCHED -- requirements
Module: amul_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, NUM_REQ bits, meaning one request-valid bit per requester.
REQ-005 SHALL have port req_ready, output, NUM_REQ bits, meaning one accept bit per requester.
REQ-006 SHALL have port req_x, input, NUM_REQ*8 bits, meaning unsigned x operand; requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_y, input, NUM_REQ*8 bits, meaning unsigned y operand, packed as req_x.
REQ-008 SHALL have port res_valid, output, 1 bit, meaning a result is presented.
REQ-009 SHALL have port res_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-010 SHALL have port res_z, output, 16 bits, meaning the product.
REQ-011 SHALL have port res_tag, output, 3 bits, meaning index of the originating requester.
REQ-012 SHALL have port acc_cnt, output, 16 bits, meaning the count of accepted requests.

Function
REQ-013 SHALL share one approximate multiplier core among all requesters and accept at most one request per cycle.
REQ-014 SHALL compute core product as (y * x[7:2]) << 2, plus bit 7 = (x[0]&y[6])|(x[1]&y[5]), plus bit 8 = x[1]&y[7], as a 16-bit unsigned sum.
REQ-015 SHALL arbitrate round-robin: search starts at pointer rr_ptr and takes the first asserted req_valid at or after it, wrapping modulo NUM_REQ.
REQ-016 SHALL assert at most one req_ready bit per cycle, only for the granted requester, and only when stage 1 can advance.
REQ-017 SHALL advance stage 1 when it is empty, or when stage 2 is empty, or when res_ready=1.
REQ-018 SHALL keep req_ready independent of res_valid of the same requester; it MAY depend combinationally on res_ready.
REQ-019 SHALL, on a handshake (req_valid&req_ready), register operands and tag into stage 1, then set rr_ptr to granted index + 1, wrapping NUM_REQ-1 to 0.
REQ-020 SHALL leave rr_ptr unchanged in cycles with no handshake.
REQ-021 SHALL compute the product between stage 1 and stage 2, giving res_valid 2 cycles after the accept edge when there is no backpressure.
REQ-022 SHALL hold res_z and res_tag stable while res_valid=1 and res_ready=0, and lose or duplicate no result.
REQ-023 SHALL sustain one result per cycle when all requesters are busy and res_ready=1.
REQ-024 SHALL increment acc_cnt on every request handshake, wrapping 0xFFFF to 0x0000.

Reset
REQ-025 SHALL, while rst_n=0 and regardless of clk, force to 0: rr_ptr, stage valids, res_valid, res_z, res_tag, acc_cnt and req_ready.
REQ-026 SHALL drop in-flight requests when reset asserts mid-operation, and emit none of them after release.
REQ-027 SHALL accept the first request no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL recognize macro AMUL_SCHED_EXACT_EN.
REQ-029 SHALL, when AMUL_SCHED_EXACT_EN is defined, add input req_exact (NUM_REQ bits) carried with the operands; req_exact=1 selects the exact x*y, 0 selects REQ-014.
REQ-030 SHALL, when AMUL_SCHED_EXACT_EN is undefined, omit req_exact and always compute REQ-014.

Structure
REQ-031 SHALL take the operand width (8), product width (16), tag width (3) and maximum NUM_REQ (8) from shared package amul_pkg.
REQ-032 SHALL implement the REQ-014 product in sub-module amul_core (pure combinational, x/y in, z out), instantiated once.

Verification
REQ-033 SHALL test: requester 0 sends x=255, y=255, res_ready=1 -> res_z=64644, res_tag=0, two cycles after accept.
REQ-034 SHALL test: x=3, y=255 -> res_z=384; x=4, y=10 -> res_z=40; with EXACT_EN and req_exact=1, x=255, y=255 -> 65025.
REQ-035 SHALL test: all 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,..., one per cycle, tags match.
REQ-036 SHALL test: res_ready=0 for 5 cycles while results are pending -> res_z/res_tag stable, req_ready=0 once both stages are full, no loss after release.
REQ-037 SHALL test: rst_n asserted with both stages full -> res_valid=0 immediately, acc_cnt=0, no stale result after release.
REQ-038 SHALL test: acc_cnt preloaded to 0xFFFF via 65535 accepts, then one more accept -> 0x0000.
